alu_sin_deframer: RTL and testbench

Serial-input receiver for the ALU. It sits directly downstream of the `sin` serial line and upstream of the arithmetic core. It deserialises 11-bit frames, assembles a 9-frame command packet (B, A, CTL), checks the CRC4 and the opcode, and presents one decoded command per packet on a valid/ready output register. It is also the RTL counterpart of the testbench's sin-side packet decoder.

---
 rtl/alu_sin_deframer_if.sv | 20 ++
 rtl/alu_sin_deframer.sv | 183 ++++++++++++++++++
 tb/tb_alu_sin_deframer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sin_deframer_if.sv
// Output command bus of the sin deframer: one decoded ALU command per
// valid/ready transfer.
interface alu_sin_deframer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [2:0]  out_err;

  modport master (
    output out_valid, out_a, out_b, out_op, out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_a, out_b, out_op, out_err,
    output out_ready
  );
endinterface

// File: rtl/alu_sin_deframer.sv
// Serial-input receiver: deserialises 11-bit frames, assembles a 9-frame
// {B, A, CTL} packet, checks CRC4/opcode and presents one command per packet.
module alu_sin_deframer (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_sin,
  alu_sin_deframer_if.master         o_cmd,
  output logic                       o_overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TYPE = 2'd1,
    ST_DATA = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  // CRC4, poly x^4+x+1, init 0, vector consumed MSB first
  function automatic logic [3:0] crc4_f(input logic [67:0] v);
    logic [3:0] c;
    logic       fb;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ v[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_bitcnt;
  logic        r_type;
  logic [7:0]  r_shift;
  logic [3:0]  r_cnt;
  logic        r_corrupt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [7:0]  r_ctl;
  logic        r_pend;
  logic        r_p_cnt_ok;
  logic        r_p_corrupt;
  logic [1:0]  w_byte_sel;
  logic [3:0]  w_crc;
  logic [2:0]  w_err;
  logic        w_load;

  logic        r_out_valid;
  logic [31:0] r_out_a;
  logic [31:0] r_out_b;
  logic [2:0]  r_out_op;
  logic [2:0]  r_out_err;
  logic        r_overrun;

  assign w_byte_sel = 2'd3 - r_cnt[1:0];
  assign w_load     = r_pend && (!r_out_valid || o_cmd.out_ready);

  // frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // frame FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!i_sin) w_state_nxt = ST_TYPE;
        else        w_state_nxt = ST_IDLE;
      end
      ST_TYPE: w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (r_bitcnt == 3'd0) w_state_nxt = ST_STOP;
        else                  w_state_nxt = ST_DATA;
      end
      ST_STOP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // bit shifting, packet assembly and packet-close capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt    <= 3'd0;
      r_type      <= 1'b0;
      r_shift     <= 8'h00;
      r_cnt       <= 4'd0;
      r_corrupt   <= 1'b0;
      r_a         <= 32'h0000_0000;
      r_b         <= 32'h0000_0000;
      r_ctl       <= 8'h00;
      r_pend      <= 1'b0;
      r_p_cnt_ok  <= 1'b0;
      r_p_corrupt <= 1'b0;
    end else begin
      r_pend <= 1'b0;
      case (r_state)
        ST_TYPE: begin
          r_type   <= i_sin;
          r_bitcnt <= 3'd7;
        end
        ST_DATA: begin
          r_shift  <= {r_shift[6:0], i_sin};
          r_bitcnt <= r_bitcnt - 3'd1;
        end
        ST_STOP: begin
          if (!i_sin) begin
            r_corrupt <= 1'b1;
          end else if (!r_type) begin
            if (r_cnt < 4'd8) begin
              if (!r_cnt[2]) r_b[{w_byte_sel, 3'b000} +: 8] <= r_shift;
              else           r_a[{w_byte_sel, 3'b000} +: 8] <= r_shift;
              r_cnt <= r_cnt + 4'd1;
            end else begin
              r_corrupt <= 1'b1;
              r_cnt     <= 4'd9;
            end
          end else begin
            // close: snapshot packet status, free counters for the next packet
            r_pend      <= 1'b1;
            r_ctl       <= r_shift;
            r_p_cnt_ok  <= (r_cnt == 4'd8);
            r_p_corrupt <= r_corrupt;
            r_cnt       <= 4'd0;
            r_corrupt   <= 1'b0;
          end
        end
        default: begin
          r_bitcnt <= r_bitcnt;
        end
      endcase
    end
  end

  // error classification of the closed packet, highest priority first
  always_comb begin
    w_crc = crc4_f({r_b, r_a, 1'b1, r_ctl[6:4]});
    if (!r_p_cnt_ok || r_p_corrupt || r_ctl[7]) begin
      w_err = 3'b100;
    end else if (r_ctl[3:0] != w_crc) begin
      w_err = 3'b010;
    end else if (r_ctl[5]) begin
      w_err = 3'b001;
    end else begin
      w_err = 3'b000;
    end
  end

  // output register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_a     <= 32'h0000_0000;
      r_out_b     <= 32'h0000_0000;
      r_out_op    <= 3'b000;
      r_out_err   <= 3'b000;
      r_overrun   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_a     <= r_a;
      r_out_b     <= r_b;
      r_out_op    <= r_ctl[6:4];
      r_out_err   <= w_err;
    end else begin
      if (r_out_valid && o_cmd.out_ready) r_out_valid <= 1'b0;
      else                                r_out_valid <= r_out_valid;
      if (r_pend) r_overrun <= 1'b1;
      else        r_overrun <= r_overrun;
    end
  end

  assign o_cmd.out_valid = r_out_valid;
  assign o_cmd.out_a     = r_out_a;
  assign o_cmd.out_b     = r_out_b;
  assign o_cmd.out_op    = r_out_op;
  assign o_cmd.out_err   = r_out_err;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_alu_sin_deframer.sv
// Directed self-checking bench for alu_sin_deframer; observed outputs are
// packed as {valid, b, a, op, err, overrun} and compared to hand values.
module tb_alu_sin_deframer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sin   = 1'b1;
  logic overrun;
  int   errors = 0;
  int   checks = 0;
  logic [71:0] obs;
  logic [71:0] exp_v;

  alu_sin_deframer_if u_if();

  alu_sin_deframer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sin     (sin),
    .o_cmd     (u_if),
    .o_overrun (overrun)
  );

  always #5 clk = ~clk;

  assign obs = {u_if.out_valid, u_if.out_b, u_if.out_a, u_if.out_op, u_if.out_err, overrun};

  function automatic logic [3:0] crc4_m(input logic [67:0] v);
    logic [3:0] c;
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      if (c[3] ^ v[i]) c = {c[2:0], 1'b0} ^ 4'b0011;
      else             c = {c[2:0], 1'b0};
    end
    return c;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [7:0] ctl);
    for (int i = 0; i < 4; i++) send_frame(1'b0, b[31-8*i -: 8], 1'b1);
    for (int i = 0; i < 4; i++) send_frame(1'b0, a[31-8*i -: 8], 1'b1);
    send_frame(1'b1, ctl, 1'b1);
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    u_if.out_ready = 1'b1;
    @(negedge clk);
    u_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sin = 1'b1; u_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    send_packet(32'h0, 32'h0, 8'h47);
    idle(2);
    exp_v = {1'b1, 32'h0, 32'h0, 3'b100, 3'b000, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL pre_reset obs=%h exp=%h", obs, exp_v); end
    send_frame(1'b0, 8'hAA, 1'b1);
    send_frame(1'b0, 8'h55, 1'b1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0; sin = 1'b1;
    #1;
    exp_v = 72'h0;
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_vals obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
    send_packet(32'h0, 32'h0, 8'h0B);
    send_bit(1'b1);
    exp_v = 72'h0;
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL latency_early obs=%h exp=%h", obs, exp_v); end
    send_bit(1'b1);
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, 3'b000, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL latency_one obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
  endtask

  task automatic test_good_add();
    send_packet(32'h0, 32'h0, 8'h47);
    idle(2);
    exp_v = {1'b1, 32'h0, 32'h0, 3'b100, 3'b000, 1'b0};
    for (int i = 0; i < 5; i++) begin
      checks++; if (obs !== exp_v) begin errors++; $display("FAIL hold_%0d obs=%h exp=%h", i, obs, exp_v); end
      @(negedge clk);
    end
    pulse_ready();
    exp_v = {1'b0, 32'h0, 32'h0, 3'b100, 3'b000, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL consume obs=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_crc_op_err();
    send_packet(32'h0, 32'h0, 8'h4B);
    idle(2);
    exp_v = {1'b1, 32'h0, 32'h0, 3'b100, 3'b010, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL crc_err obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
    send_packet(32'h0, 32'h0, 8'h2D);
    idle(2);
    exp_v = {1'b1, 32'h0, 32'h0, 3'b010, 3'b001, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL op_err obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
    send_packet(32'h0, 32'h0, 8'h2E);
    idle(2);
    exp_v = {1'b1, 32'h0, 32'h0, 3'b010, 3'b010, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL op_crc_err obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
  endtask

  task automatic test_data_err();
    logic [7:0] d;
    d = 8'h11;
    for (int i = 0; i < 7; i++) begin
      send_frame(1'b0, d, 1'b1);
      d = d + 8'h11;
    end
    send_frame(1'b1, 8'h0B, 1'b1);
    idle(2);
    exp_v = {1'b1, 32'h1122_3344, 32'h5566_7700, 3'b000, 3'b100, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL short_pkt obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
    send_packet(32'h0, 32'h0, 8'h0B);
    idle(2);
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, 3'b000, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL eight_ok obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
    for (int i = 0; i < 9; i++) send_frame(1'b0, 8'h00, (i != 2));
    send_frame(1'b1, 8'h0B, 1'b1);
    idle(2);
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, 3'b100, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL bad_stop obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
    for (int i = 0; i < 9; i++) send_frame(1'b0, 8'h00, 1'b1);
    send_frame(1'b1, 8'h0B, 1'b1);
    idle(2);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL nine_data obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
    send_packet(32'h0, 32'h0, 8'h8B);
    idle(2);
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL ctl_bit7 obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
  endtask

  task automatic test_good_data();
    logic [31:0] b;
    logic [31:0] a;
    logic [7:0]  ctl;
    b   = 32'h1234_5678;
    a   = 32'h9ABC_DEF0;
    ctl = {1'b0, 3'b101, crc4_m({b, a, 1'b1, 3'b101})};
    for (int i = 0; i < 4; i++) begin
      send_frame(1'b0, b[31-8*i -: 8], 1'b1);
      idle(i);
    end
    for (int i = 0; i < 4; i++) send_frame(1'b0, a[31-8*i -: 8], 1'b1);
    idle(7);
    send_frame(1'b1, ctl, 1'b1);
    idle(2);
    exp_v = {1'b1, b, a, 3'b101, 3'b000, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL good_data obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
  endtask

  task automatic test_back_to_back();
    send_packet(32'h0, 32'h0, 8'h0B);
    send_packet(32'h0, 32'h0, 8'h47);
    @(negedge clk);
    sin = 1'b1; u_if.out_ready = 1'b1;
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, 3'b000, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_first obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    u_if.out_ready = 1'b0;
    exp_v = {1'b1, 32'h0, 32'h0, 3'b100, 3'b000, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL b2b_reload obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
  endtask

  task automatic test_overrun();
    u_if.out_ready = 1'b0;
    send_packet(32'h0, 32'h0, 8'h0B);
    send_packet(32'h0, 32'h0, 8'h47);
    idle(2);
    exp_v = {1'b1, 32'h0, 32'h0, 3'b000, 3'b000, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL overrun_set obs=%h exp=%h", obs, exp_v); end
    pulse_ready();
    idle(20);
    exp_v = {1'b0, 32'h0, 32'h0, 3'b000, 3'b000, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL overrun_sticky obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_v = 72'h0;
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL overrun_clear obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    u_if.out_ready = 1'b0;
    test_reset();
    test_good_add();
    test_crc_op_err();
    test_data_err();
    test_good_data();
    test_back_to_back();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
